// File: rtl/poly_voice_mix_pkg.sv
// Shared types and sizing helpers for the polyphonic voice mixer.
package poly_voice_pkg;

  // How the two oscillator samples of a voice are combined.
  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_OSC0 = 2'd1,
    MODE_RING = 2'd2,
    MODE_DIFF = 2'd3
  } mix_mode_e;

  // Mix sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_MASTER = 3'd3,
    ST_SAT    = 3'd4
  } mix_state_e;

  // Accumulator width: one W-bit term per voice plus a sign guard bit.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
    return w + $clog2(n) + 1;
  endfunction

  // Voice index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/poly_voice_mix_combine.sv
// Combines one oscillator pair into a single W-bit signed sample.
module voice_combine
  import poly_voice_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0] osc0,
  input  logic signed [W-1:0] osc1,
  input  mix_mode_e           mode,
  output logic signed [W-1:0] c
);

  logic signed [W:0]     sum_w;
  logic signed [W:0]     diff_w;
  logic signed [2*W-1:0] osc0_x;
  logic signed [2*W-1:0] osc1_x;
  logic signed [2*W-1:0] ring_w;
  logic                  unused_bits;

  // Halved sum/difference and Q1.(W-1) ring product, selected by mode.
  always_comb begin
    sum_w  = {osc0[W-1], osc0} + {osc1[W-1], osc1};
    diff_w = {osc0[W-1], osc0} - {osc1[W-1], osc1};
    osc0_x = {{W{osc0[W-1]}}, osc0};
    osc1_x = {{W{osc1[W-1]}}, osc1};
    ring_w = osc0_x * osc1_x;
    unused_bits = ^{sum_w[0], diff_w[0], ring_w[W-2:0]};
    c = osc0;
    case (mode)
      MODE_SUM:  c = sum_w[W:1];
      MODE_OSC0: c = osc0;
      MODE_RING: begin
        // Only (-max)*(-max) sets bit 2W-2 without the sign bit.
        if (ring_w[2*W-1] != ring_w[2*W-2]) begin
          c = {1'b0, {(W-1){1'b1}}};
        end else begin
          c = ring_w[2*W-2:W-1];
        end
      end
      MODE_DIFF: c = diff_w[W:1];
      default:   c = osc0;
    endcase
  end

endmodule

// File: rtl/poly_voice_mix.sv
// Time-multiplexed voice mixer: snapshot, per-voice env scaling through
// one shared multiplier, accumulation, master gain and saturation.
module poly_voice_mix
  import poly_voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned W          = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  sample_tick,
  input  logic [NUM_VOICES*W-1:0] osc0_in,
  input  logic [NUM_VOICES*W-1:0] osc1_in,
  input  logic [NUM_VOICES*W-1:0] env_in,
  input  logic [NUM_VOICES-1:0] voice_en,
  input  logic [1:0]            mode,
  input  logic [W-1:0]          master_gain,
  input  logic                  overrun_clr,
  output logic [W-1:0]          out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned A  = acc_width(W, NUM_VOICES);
  localparam int unsigned IW = idx_width(NUM_VOICES);
  localparam int unsigned PW = 2*W + 1;
  localparam int unsigned MW = A + W + 1;

  mix_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [NUM_VOICES*W-1:0] osc0_s_q, osc0_s_d;
  logic [NUM_VOICES*W-1:0] osc1_s_q, osc1_s_d;
  logic [NUM_VOICES*W-1:0] env_s_q, env_s_d;
  logic [NUM_VOICES-1:0]   en_s_q, en_s_d;
  mix_mode_e               mode_s_q, mode_s_d;
  logic [W-1:0]            gain_s_q, gain_s_d;
  logic                    snap_load;

  logic signed [W-1:0] p_q, p_d;
  logic                p_valid_q, p_valid_d;
  logic signed [A-1:0] acc_q, acc_d;
  logic signed [A-1:0] m_q, m_d;
  logic [W-1:0]        out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;

  logic [31:0]          sel_base;
  logic signed [W-1:0]  cur_osc0, cur_osc1, comb_c;
  logic [W-1:0]         cur_env;
  logic                 cur_en;
  logic signed [PW-1:0] env_a, env_b, env_prod;
  logic signed [MW-1:0] mst_a, mst_b, mst_prod;
  logic [A-W:0]         m_hi;
  logic                 unused_bits;

  // Pick the current voice out of the snapshot.
  always_comb begin
    sel_base = W * 32'(idx_q);
    cur_osc0 = osc0_s_q[sel_base +: W];
    cur_osc1 = osc1_s_q[sel_base +: W];
    cur_env  = env_s_q[sel_base +: W];
    cur_en   = en_s_q[idx_q];
  end

  voice_combine #(.W(W)) u_combine (
    .osc0 (cur_osc0),
    .osc1 (cur_osc1),
    .mode (mode_s_q),
    .c    (comb_c)
  );

  // Shared multipliers; unsigned operands are zero-extended so the signed
  // product is exact, then the W fractional bits are dropped (floor).
  always_comb begin
    env_a    = {{(W+1){comb_c[W-1]}}, comb_c};
    env_b    = {{(W+1){1'b0}}, cur_env};
    env_prod = env_a * env_b;
    mst_a    = {{(W+1){acc_q[A-1]}}, acc_q};
    mst_b    = {{(A+1){1'b0}}, gain_s_q};
    mst_prod = mst_a * mst_b;
    m_hi     = m_q[A-1:W-1];
    unused_bits = ^{env_prod[PW-1:2*W], env_prod[W-1:0],
                    mst_prod[MW-1:A+W], mst_prod[W-1:0]};
  end

  // Snapshot capture on an accepted tick, otherwise hold.
  always_comb begin
    osc0_s_d = osc0_s_q;
    osc1_s_d = osc1_s_q;
    env_s_d  = env_s_q;
    en_s_d   = en_s_q;
    mode_s_d = mode_s_q;
    gain_s_d = gain_s_q;
    if (snap_load) begin
      osc0_s_d = osc0_in;
      osc1_s_d = osc1_in;
      env_s_d  = env_in;
      en_s_d   = voice_en;
      mode_s_d = mix_mode_e'(mode);
      gain_s_d = master_gain;
    end
  end

  // Sequencer, two-stage voice pipeline, master gain and saturation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    p_d         = p_q;
    p_valid_d   = 1'b0;
    acc_d       = acc_q;
    m_d         = m_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    snap_load   = 1'b0;

    // Stage 2 runs whenever stage 1 produced a term last cycle.
    if (p_valid_q) begin
      acc_d = acc_q + {{(A-W){p_q[W-1]}}, p_q};
    end

    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          snap_load = 1'b1;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        p_d       = cur_en ? env_prod[2*W-1:W] : '0;
        p_valid_d = 1'b1;
        if (idx_q == IW'(NUM_VOICES - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_MASTER;
      end
      ST_MASTER: begin
        m_d     = mst_prod[A+W-1:W];
        state_d = ST_SAT;
      end
      ST_SAT: begin
        if ((&m_hi) || !(|m_hi)) begin
          out_d = m_q[W-1:0];
        end else if (m_q[A-1]) begin
          out_d = {1'b1, {(W-1){1'b0}}};
        end else begin
          out_d = {1'b0, {(W-1){1'b1}}};
        end
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overrun; a new illegal tick beats a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (sample_tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      acc_q       <= '0;
      m_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Snapshot registers carry no reset; they are always loaded before use.
  always_ff @(posedge Clk) begin
    osc0_s_q <= osc0_s_d;
    osc1_s_q <= osc1_s_d;
    env_s_q  <= env_s_d;
    en_s_q   <= en_s_d;
    mode_s_q <= mode_s_d;
    gain_s_q <= gain_s_d;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_poly_voice_mix.sv
// Bench for poly_voice_mix: cycle timeline model plus directed vectors.
module tb_poly_voice_mix;

  localparam int N = 4;
  localparam int W = 16;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           sample_tick;
  logic [N*W-1:0] osc0_in, osc1_in, env_in;
  logic [N-1:0]   voice_en;
  logic [1:0]     mode;
  logic [W-1:0]   master_gain;
  logic           overrun_clr;
  logic [W-1:0]   out;
  logic           out_valid, busy, overrun;

  always #5 Clk = ~Clk;

  poly_voice_mix #(.NUM_VOICES(N), .W(W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .sample_tick (sample_tick),
    .osc0_in     (osc0_in),
    .osc1_in     (osc1_in),
    .env_in      (env_in),
    .voice_en    (voice_en),
    .mode        (mode),
    .master_gain (master_gain),
    .overrun_clr (overrun_clr),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference of one complete mix.
  function automatic logic [W-1:0] model_mix(input logic [N*W-1:0] o0, input logic [N*W-1:0] o1,
                                             input logic [N*W-1:0] e, input logic [N-1:0] en,
                                             input logic [1:0] md, input logic [W-1:0] g);
    longint acc, a, b, c, ev, m;
    longint maxv, minv;
    logic signed [W-1:0] s0, s1;
    maxv = (longint'(1) <<< (W-1)) - 1;
    minv = -(longint'(1) <<< (W-1));
    acc = 0;
    for (int i = 0; i < N; i++) begin
      s0 = o0[i*W +: W];
      s1 = o1[i*W +: W];
      a  = s0;
      b  = s1;
      ev = longint'(e[i*W +: W]);
      case (md)
        2'd0: c = (a + b) >>> 1;
        2'd1: c = a;
        2'd2: begin
          c = (a * b) >>> (W-1);
          if (c > maxv) c = maxv;
        end
        default: c = (a - b) >>> 1;
      endcase
      if (en[i]) acc = acc + ((c * ev) >>> W);
    end
    m = (acc * longint'(g)) >>> W;
    if (m > maxv) m = maxv;
    if (m < minv) m = minv;
    return W'(m);
  endfunction

  // Timeline model: what each output must show in the coming cycle.
  logic [W-1:0] exp_out, pend;
  logic         exp_valid, exp_busy, exp_ovr;
  int           left;
  bit           model_ok = 1'b0;

  always @(posedge Clk) begin : model
    int l;
    logic [W-1:0] o;
    logic v, ov, was_busy;
    if (Reset) begin
      left      <= 0;
      exp_out   <= '0;
      exp_valid <= 1'b0;
      exp_busy  <= 1'b0;
      exp_ovr   <= 1'b0;
      model_ok  <= 1'b1;
    end else begin
      l  = left;
      o  = exp_out;
      ov = exp_ovr;
      v  = 1'b0;
      was_busy = (l > 0);
      if (l > 0) begin
        l = l - 1;
        if (l == 0) begin
          o = pend;
          v = 1'b1;
        end
      end
      if (sample_tick && !was_busy) begin
        pend <= model_mix(osc0_in, osc1_in, env_in, voice_en, mode, master_gain);
        l = N + 3;
      end
      if (sample_tick && was_busy) ov = 1'b1;
      else if (overrun_clr) ov = 1'b0;
      left      <= l;
      exp_out   <= o;
      exp_valid <= v;
      exp_busy  <= (l > 0);
      exp_ovr   <= ov;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clk) begin
    if (model_ok) begin
      check("sb_out", 32'(out), 32'(exp_out));
      check("sb_out_valid", 32'(out_valid), 32'(exp_valid));
      check("sb_busy", 32'(busy), 32'(exp_busy));
      check("sb_overrun", 32'(overrun), 32'(exp_ovr));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_all(input logic [W-1:0] o0, input logic [W-1:0] o1, input logic [W-1:0] e,
                         input logic [N-1:0] en, input logic [1:0] md, input logic [W-1:0] g);
    osc0_in = {N{o0}};
    osc1_in = {N{o1}};
    env_in  = {N{e}};
    voice_en = en;
    mode = md;
    master_gain = g;
  endtask

  // Tick once, scramble inputs, wait for the result and check latency/value.
  task automatic mix_run(input string name, input bit use_lit, input logic [W-1:0] exp_lit);
    int lat;
    logic [W-1:0] ref_v;
    ref_v = use_lit ? exp_lit : model_mix(osc0_in, osc1_in, env_in, voice_en, mode, master_gain);
    lat = -1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    osc0_in = {$urandom, $urandom};
    osc1_in = {$urandom, $urandom};
    env_in  = {$urandom, $urandom};
    voice_en = N'($urandom);
    mode = 2'($urandom);
    master_gain = W'($urandom);
    for (int k = 1; k <= N + 10 && lat < 0; k++) begin
      if (out_valid === 1'b1) lat = k;
      else step();
    end
    check({name, "_latency"}, 32'(lat), 32'(N + 4));
    check({name, "_out"}, 32'(out), 32'(ref_v));
    step();
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      if (out_valid === 1'b1) cnt++;
      step();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int pulses;
    Reset = 1'b1;
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    set_all('0, '0, '0, '0, 2'd0, '0);
    step(); step(); step();
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    Reset = 1'b0;
    step();

    set_all(16'h2000, 16'h2000, 16'h8000, 4'b0001, 2'd0, 16'h8000);
    mix_run("sum_v0", 1'b1, 16'h0800);

    set_all(16'h4000, 16'h4000, 16'hFFFF, 4'b1111, 2'd0, 16'hFFFF);
    mix_run("sum_pos_sat", 1'b1, 16'h7FFF);

    set_all(16'h8000, 16'h8000, 16'hFFFF, 4'b1111, 2'd0, 16'hFFFF);
    mix_run("sum_neg_sat", 1'b1, 16'h8000);

    set_all(16'h8000, 16'h8000, 16'hFFFF, 4'b0001, 2'd2, 16'hFFFF);
    mix_run("ring_clamp", 1'b1, 16'h7FFD);

    set_all(16'h0, 16'h0, 16'hFFFF, 4'b0001, 2'd3, 16'hFFFF);
    osc0_in = {16'h1234, 16'h5555, 16'h7000, 16'h3000};
    osc1_in = {16'h4321, 16'h2222, 16'h0100, 16'h1000};
    mix_run("diff_v0", 1'b1, 16'h0FFE);

    set_all(16'h0, 16'h5A5A, 16'h0, 4'b0111, 2'd1, 16'h8000);
    osc0_in = {16'h7FFF, 16'h0100, 16'hF000, 16'h0800};
    env_in  = {16'hFFFF, 16'hFFFF, 16'h4000, 16'h8000};
    mix_run("osc0_mixed", 1'b1, 16'h007F);

    for (int r = 0; r < 6; r++) begin
      osc0_in = {$urandom, $urandom};
      osc1_in = {$urandom, $urandom};
      env_in  = {$urandom, $urandom};
      voice_en = N'($urandom);
      mode = 2'(r);
      master_gain = W'($urandom);
      mix_run("random", 1'b0, '0);
    end

    // Second tick three cycles after the first is rejected.
    set_all(16'h2000, 16'h2000, 16'h8000, 4'b0001, 2'd0, 16'h8000);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step(); step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    count_pulses(12, pulses);
    check("ovr_single_pulse", 32'(pulses), 32'd1);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_out", 32'(out), 32'h0800);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Clear coinciding with an illegal tick leaves overrun set.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    step();
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'h1);
    count_pulses(12, pulses);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;

    // Reset in the middle of a mix.
    set_all(16'h4000, 16'h4000, 16'hFFFF, 4'b1111, 2'd0, 16'hFFFF);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    count_pulses(10, pulses);
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    set_all(16'h8000, 16'h8000, 16'hFFFF, 4'b0001, 2'd2, 16'hFFFF);
    mix_run("after_rst", 1'b1, 16'h7FFD);

    // Back-to-back at the minimum legal period.
    set_all(16'h2000, 16'h2000, 16'h8000, 4'b0001, 2'd0, 16'h8000);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int k = 1; k < N + 4; k++) step();
    set_all(16'h4000, 16'h4000, 16'hFFFF, 4'b1111, 2'd0, 16'hFFFF);
    check("b2b_first_out", 32'(out), 32'h0800);
    mix_run("b2b_second", 1'b1, 16'h7FFF);
    check("b2b_no_overrun", 32'(overrun), 32'h0);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_voice_mix.md
# poly_voice_mix

Parametrised, time-multiplexed mixer for a bank of NUM_VOICES synth voices. On each sample strobe it snapshots every voice's two oscillator samples and envelope level, combines each pair per a selectable mode, scales it by its envelope, accumulates all enabled voices, applies a master gain and saturates to one output sample. It sits between the per-voice NCO/ADSR instances and the audio codec interface, replacing per-voice combinational multiply-and-sum with one shared multiplier path.

## Interface
- NUM_VOICES, 4: voice count, ≥1.
- W, 16: sample/envelope/gain width.
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- sample_tick  in  1  one-cycle strobe requesting a new output sample.
- osc0_in  in  NUM_VOICES*W  signed oscillator-0 samples, voice i at [i*W +: W].
- osc1_in  in  NUM_VOICES*W  signed oscillator-1 samples, same packing.
- env_in  in  NUM_VOICES*W  unsigned envelope levels (0 = silent, 2^W-1 ≈ unity).
- voice_en  in  NUM_VOICES  per-voice enable; a disabled voice contributes 0.
- mode  in  2  combine mode.
- master_gain  in  W  unsigned master gain.
- overrun_clr  in  1  clears overrun.
- out  out  W  signed mixed sample.
- out_valid  out  1  one-cycle pulse when out updates.
- busy  out  1  mix in progress.
- overrun  out  1  sticky: sample_tick arrived while busy.

## Operation
- States: IDLE, RUN, DRAIN, MASTER, SAT.
- IDLE: sample_tick registers all inputs (osc, env, voice_en, mode, master_gain) into a snapshot, clears accumulator, idx←0, goes to RUN. Inputs may change freely afterwards.
- RUN: one voice per cycle, idx 0..NUM_VOICES-1. Stage 1 computes combined sample c (W bits signed) and registers p = en ? (c * env) >>> W : 0. Stage 2 adds registered p into the accumulator (W+clog2(NUM_VOICES)+1 bits signed). After idx = NUM_VOICES-1, go to DRAIN.
- DRAIN: last p accumulated; go to MASTER.
- MASTER: m = (acc * master_gain) >>> W, registered; go to SAT.
- SAT: out ← clamp(m, -2^(W-1), 2^(W-1)-1), out_valid pulses next cycle; go to IDLE.
- Combine modes: 0 SUM: (osc0+osc1) in W+1 bits, take [W:1]. 1 OSC0: osc0. 2 RING: (osc0*osc1) in 2W bits, take [2W-2:W-1], clamp to +2^(W-1)-1 on (-max)·(-max) overflow. 3 DIFF: (osc0-osc1) in W+1 bits, take [W:1].
- All right shifts arithmetic (floor). Env and master_gain zero-extended before signed multiply.
- sample_tick outside IDLE: ignored, overrun←1. overrun clears only on overrun_clr or Reset; set wins if both occur together.
- Reset at any time: state IDLE, accumulator and pipeline discarded, out=0, out_valid=0, busy=0, overrun=0. Snapshot registers need no reset.

## Timing
- Tick sampled in cycle T: busy high in cycles T+1..T+NUM_VOICES+3; out and out_valid visible in cycle T+NUM_VOICES+4 (latency NUM_VOICES+4).
- out holds its value between pulses.
- Minimum legal tick period NUM_VOICES+4 cycles; a tick in cycle T+NUM_VOICES+4 is accepted (state IDLE).
- NUM_VOICES=1: RUN lasts one cycle, latency 5.

## Structure
- Package poly_voice_pkg: mode enum (MODE_SUM, MODE_OSC0, MODE_RING, MODE_DIFF), state enum, accumulator-width function.
- Sub-module voice_combine: mode-based combining of one osc pair, including RING clamp, instantiated once in stage 1.
- One shared multiplier for env and one for master gain; no per-voice multipliers.

## Test plan
(W=16, NUM_VOICES=4.)
- Voice 0 only enabled, osc0=osc1=0x2000, env=0x8000, mode 0, master 0x8000 -> out=0x0800, out_valid in cycle T+8.
- All voices enabled, osc0=osc1=0x4000, env=0xFFFF, mode 0, master 0xFFFF -> acc=0xFFFC, out saturates to 0x7FFF.
- All voices, osc0=osc1=0x8000, env=0xFFFF, mode 0, master 0xFFFF -> out=0x8000 (negative saturation).
- Voice 0 only, osc0=osc1=0x8000, mode 2, env=0xFFFF, master 0xFFFF -> clamp to 0x7FFF, p=0x7FFE, out=0x7FFD.
- Ticks 3 cycles apart -> second ignored, overrun=1, single out_valid; overrun_clr -> overrun=0; simultaneous clr and illegal tick -> overrun stays 1.
- Reset asserted during RUN -> next cycle busy=0, out=0, no out_valid; next tick mixes correctly from a clean accumulator.
